// File: rtl/mux_n_scan.sv
// N-channel, W-bit registered multiplexer.
// Manual mode follows sel; scan mode steps round-robin, dwelling DWELL cycles per channel.
module mux_n_scan #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*W-1:0]   d,
    input  logic [SEL_W-1:0] sel,
    input  logic             scan_en,
    input  logic             hold,
    output logic [W-1:0]     q,
    output logic [SEL_W-1:0] ch,
    output logic             step
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [SEL_W-1:0] ch_nx;
    logic [W-1:0]     q_nx;

    // Dropping scan_en takes priority, so a falling edge at a dwell boundary lands on sel.
    always_comb begin
        ch_nx  = ch;
        cnt_nx = cnt;
        if (!scan_en) begin
            ch_nx  = ({1'b0, sel} < N_EXT) ? sel : '0;
            cnt_nx = '0;
        end else if (state == MANUAL) begin
            cnt_nx = '0;
        end else if (!hold) begin
            if (cnt == LAST_CNT) begin
                ch_nx  = (ch == LAST_CH) ? '0 : ch + 1'b1;
                cnt_nx = '0;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        q_nx = '0;
        for (int i = 0; i < N; i++) begin
            if (ch_nx == SEL_W'(i)) begin
                q_nx = d[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MANUAL;
            cnt   <= '0;
            ch    <= '0;
            q     <= '0;
            step  <= 1'b0;
        end else begin
            state <= scan_en ? SCAN : MANUAL;
            cnt   <= cnt_nx;
            ch    <= ch_nx;
            q     <= q_nx;
            step  <= (ch_nx != ch);
        end
    end

endmodule
